// File: rtl/simon_serial_core.sv
// Nibble-serial Simon block cipher core (m = 4 key words), parametrised word size and rounds.
// One 6N-bit register holds {x, y, k3, k2, k1, k0}; one round or key step per clock.
module simon_serial_core #(
  parameter int          WORD_W = 16,
  parameter int          ROUNDS = 32,
  parameter logic [61:0] Z_SEQ  = 62'h3E8958737D12B0E6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_shift,
  input  logic [3:0] i_data,
  input  logic       i_start,
  input  logic       i_decrypt,
  output logic [3:0] o_data,
  output logic       o_busy,
  output logic       o_done
);

  localparam int REG_W = 6 * WORD_W;
  localparam int CNT_W = $clog2(ROUNDS + 1);
  localparam logic [WORD_W-1:0] C_CONST = {{(WORD_W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, EXPAND, ROUND} state_t;

  state_t            state_q;
  logic [REG_W-1:0]  st_q;
  logic              decrypt_q;
  logic [CNT_W-1:0]  rnd_q;
  logic [5:0]        zidx_q;
  logic              busy_q;
  logic              done_q;

  function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] v, input int unsigned s);
    return (v << s) | (v >> (WORD_W - s));
  endfunction

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] v, input int unsigned s);
    return (v >> s) | (v << (WORD_W - s));
  endfunction

  function automatic logic [WORD_W-1:0] simon_f(input logic [WORD_W-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  // Same recurrence serves both directions: forward solves for k[i+4], inverse for k[r].
  function automatic logic [WORD_W-1:0] key_step(input logic [WORD_W-1:0] far,
                                                 input logic [WORD_W-1:0] near,
                                                 input logic [WORD_W-1:0] other,
                                                 input logic              zb);
    logic [WORD_W-1:0] tmp;
    tmp = ror(far, 3) ^ near;
    return C_CONST ^ {{(WORD_W-1){1'b0}}, zb} ^ other ^ tmp ^ ror(tmp, 1);
  endfunction

  logic [WORD_W-1:0] x, y, k3, k2, k1, k0;
  logic [WORD_W-1:0] fwd_key, inv_key;
  logic              z_bit, last_step;
  logic [5:0]        zidx_inc, zidx_dec;
  logic [REG_W-1:0]  enc_next, exp_next, dec_next;

  assign {x, y, k3, k2, k1, k0} = st_q;
  assign z_bit     = Z_SEQ[6'd61 - zidx_q];
  assign fwd_key   = key_step(k3, k1, k0, z_bit);
  assign inv_key   = key_step(k2, k0, k3, z_bit);
  assign last_step = (rnd_q == CNT_W'(ROUNDS - 1));
  assign zidx_inc  = (zidx_q == 6'd61) ? 6'd0  : zidx_q + 6'd1;
  assign zidx_dec  = (zidx_q == 6'd0)  ? 6'd61 : zidx_q - 6'd1;

  assign enc_next = {y ^ simon_f(x) ^ k0, x, fwd_key, k3, k2, k1};
  assign exp_next = {x, y, fwd_key, k3, k2, k1};
  assign dec_next = {y, x ^ simon_f(y) ^ inv_key, k2, k1, k0, inv_key};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      st_q      <= '0;
      decrypt_q <= 1'b0;
      rnd_q     <= '0;
      zidx_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            decrypt_q <= i_decrypt;
            state_q   <= i_decrypt ? EXPAND : ROUND;
            busy_q    <= 1'b1;
            rnd_q     <= '0;
            zidx_q    <= '0;
          end else if (i_shift) begin
            st_q <= {st_q[REG_W-5:0], i_data};
          end
        end
        EXPAND: begin
          st_q <= exp_next;
          if (last_step) begin
            // z index stays on T-1: the first inverse round uses the last forward index.
            state_q <= ROUND;
            rnd_q   <= '0;
          end else begin
            rnd_q  <= rnd_q + 1'b1;
            zidx_q <= zidx_inc;
          end
        end
        ROUND: begin
          st_q   <= decrypt_q ? dec_next : enc_next;
          zidx_q <= decrypt_q ? zidx_dec : zidx_inc;
          if (last_step) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            rnd_q <= rnd_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_data = st_q[REG_W-1 -: 4];
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule
